// File: rtl/mac_unit_pkg.sv
// mac_unit_pkg: shared FSM encoding and default widths for the multiply-accumulate unit
package mac_unit_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int REG_ADDR_W_DEF = 5;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MUL = 2'd2, WB = 2'd3} state_t;
endpackage

// File: rtl/mac_unit_shift_add_multiplier.sv
// shift_add_multiplier: one partial product per step, WIDTH steps per multiply
module shift_add_multiplier import mac_unit_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcand_in,
   input  logic [WIDTH-1:0]   mplier_in,
   output logic [2*WIDTH-1:0] product_nxt,
   output logic               last
);
   localparam int CW = $clog2(WIDTH);
   logic [2*WIDTH-1:0] mcand_q, mcand_d, product_q, product_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      count_q, count_d;
   // mcand shifts left each step, so it always equals mcand << count
   always_comb begin
      product_nxt = product_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d     = load ? {{WIDTH{1'b0}}, mcand_in} : step ? mcand_q << 1 : mcand_q;
      mplier_d    = load ? mplier_in : step ? mplier_q >> 1 : mplier_q;
      product_d   = load ? '0 : step ? product_nxt : product_q;
      count_d     = load ? '0 : step ? count_q + 1'b1 : count_q;
      last        = count_q == CW'(WIDTH - 1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         product_q <= '0;
         count_q   <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         product_q <= product_d;
         count_q   <= count_d;
      end
   end
endmodule

// File: rtl/mac_unit.sv
// mac_unit: multi-cycle rd = rd + rs*rt (or rs*rt) unit feeding the register bank write port
module mac_unit import mac_unit_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  accumulate,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [WIDTH-1:0]      source1_data,
   input  logic [WIDTH-1:0]      source2_data,
   input  logic [WIDTH-1:0]      destination_reg_data,
   output logic                  mac_control,
   output logic [REG_ADDR_W-1:0] destination_mac,
   output logic                  write,
   output logic [REG_ADDR_W-1:0] destination_register,
   output logic [WIDTH-1:0]      wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf
);
   state_t                state_q, state_d;
   logic                  accept, fin, last, accum_q, accum_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d, destination_mac_q, destination_mac_d;
   logic [REG_ADDR_W-1:0] destination_register_q, destination_register_d;
   logic [WIDTH-1:0]      acc_q, acc_d, wr_data_q, wr_data_d;
   logic [WIDTH:0]        sum;
   logic [2*WIDTH-1:0]    product_nxt;
   logic                  mac_control_q, mac_control_d, write_q, write_d;
   logic                  busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (accept),
      .step        (state_q == MUL),
      .mcand_in    (source1_data),
      .mplier_in   (source2_data),
      .product_nxt (product_nxt),
      .last        (last)
   );
   // WB also accepts start so back-to-back ops lose no cycle
   always_comb begin
      accept  = start && (state_q == IDLE || state_q == WB);
      fin     = state_q == MUL && last;
      state_d = accept ? LOAD : state_q == LOAD ? MUL : fin ? WB : state_q == MUL ? MUL : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   // writeback is registered from the final step's product so write is glitch-free
   always_comb begin
      rd_d                   = accept ? rd_addr : rd_q;
      accum_d                = accept ? accumulate : accum_q;
      acc_d                  = state_q == LOAD ? (accum_q ? destination_reg_data : '0) : acc_q;
      mac_control_d          = accept;
      destination_mac_d      = accept ? rd_addr : destination_mac_q;
      sum                    = {1'b0, product_nxt[WIDTH-1:0]} + {1'b0, acc_q};
      write_d                = fin;
      done_d                 = fin;
      destination_register_d = fin ? rd_q : destination_register_q;
      wr_data_d              = fin ? sum[WIDTH-1:0] : wr_data_q;
      ovf_d                  = fin ? (|product_nxt[2*WIDTH-1:WIDTH]) | sum[WIDTH] : ovf_q;
      busy_d                 = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q                   <= '0;
         accum_q                <= 1'b0;
         acc_q                  <= '0;
         mac_control_q          <= 1'b0;
         destination_mac_q      <= '0;
         write_q                <= 1'b0;
         done_q                 <= 1'b0;
         destination_register_q <= '0;
         wr_data_q              <= '0;
         ovf_q                  <= 1'b0;
         busy_q                 <= 1'b0;
      end else begin
         rd_q                   <= rd_d;
         accum_q                <= accum_d;
         acc_q                  <= acc_d;
         mac_control_q          <= mac_control_d;
         destination_mac_q      <= destination_mac_d;
         write_q                <= write_d;
         done_q                 <= done_d;
         destination_register_q <= destination_register_d;
         wr_data_q              <= wr_data_d;
         ovf_q                  <= ovf_d;
         busy_q                 <= busy_d;
      end
   end
   assign mac_control          = mac_control_q;
   assign destination_mac      = destination_mac_q;
   assign write                = write_q;
   assign destination_register = destination_register_q;
   assign wr_data              = wr_data_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign ovf                  = ovf_q;
endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: directed checks of latency, writeback data, overflow, start filtering and reset abort
module tb_mac_unit;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, accumulate = 1'b0;
   logic [4:0]  rd_addr = '0;
   logic [31:0] source1_data = '0, source2_data = '0, destination_reg_data = '0;
   logic        mac_control, write, busy, done, ovf;
   logic [4:0]  destination_mac, destination_register;
   logic [31:0] wr_data;
   int          checks = 0, passed = 0, cyc = 0;

   mac_unit dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .start                (start),
      .accumulate           (accumulate),
      .rd_addr              (rd_addr),
      .source1_data         (source1_data),
      .source2_data         (source2_data),
      .destination_reg_data (destination_reg_data),
      .mac_control          (mac_control),
      .destination_mac      (destination_mac),
      .write                (write),
      .destination_register (destination_register),
      .wr_data              (wr_data),
      .busy                 (busy),
      .done                 (done),
      .ovf                  (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // one op from start to two idle cycles after WB; optional stray starts at cycles 5 and 20
   task automatic run_op(input string tag, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] rd, input logic [31:0] acc, input logic accum,
                         input logic [31:0] exp_data, input logic exp_ovf, input logic prev_ovf,
                         input logic stray);
      int nw = 0, wcyc = 0, nmc = 0, nb = 0;
      logic [31:0] got_data = '0;
      logic [4:0]  got_dest = '0;
      logic        got_ovf = 1'b0, got_done = 1'b0;
      start = 1'b1; source1_data = rs; source2_data = rt; rd_addr = rd;
      accumulate = accum; destination_reg_data = acc;
      cyc = 0;
      tick();
      start = 1'b0; source1_data = 32'h5A5A_5A5A; source2_data = 32'hA5A5_A5A5;
      rd_addr = ~rd; accumulate = ~accum;
      chk({tag, " destination_mac"}, destination_mac, rd);
      while (cyc <= 36) begin
         if (write) begin
            nw++; wcyc = cyc; got_data = wr_data; got_dest = destination_register;
            got_ovf = ovf; got_done = done;
         end
         nmc += int'(mac_control);
         nb += int'(busy);
         if (cyc == 2) begin
            chk({tag, " ovf held"}, ovf, prev_ovf);
            destination_reg_data = 32'hDEAD_BEEF;
         end
         start = stray && (cyc == 5 || cyc == 20);
         if (cyc == 36) break;
         tick();
      end
      chk({tag, " write count"}, nw, 1);
      chk({tag, " write cycle"}, wcyc, 34);
      chk({tag, " wr_data"}, got_data, exp_data);
      chk({tag, " destination_register"}, got_dest, rd);
      chk({tag, " ovf"}, got_ovf, exp_ovf);
      chk({tag, " done with write"}, got_done, 1'b1);
      chk({tag, " mac_control cycles"}, nmc, 1);
      chk({tag, " busy cycles"}, nb, 34);
      chk({tag, " ovf after op"}, ovf, exp_ovf);
      chk({tag, " idle after op"}, {busy, done, write}, 3'b000);
   endtask

   initial begin
      int nw, w1, w2, mc1, mc2, nmc;
      logic [31:0] d1, d2;
      logic [4:0]  a1, a2;
      #12;
      chk("reset outputs", {mac_control, write, busy, done, ovf}, 5'b0);
      chk("reset data", {wr_data, destination_register, destination_mac}, 42'b0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      run_op("basic", 32'd3, 32'd5, 5'd7, 32'd10, 1'b1, 32'd25, 1'b0, 1'b0, 1'b0);
      run_op("high ovf", 32'hFFFF_FFFF, 32'd2, 5'd3, 32'h1234, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
      run_op("carry ovf", 32'd1, 32'd1, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0);
      run_op("stray start", 32'd1234, 32'd1000, 5'd31, 32'd7, 1'b1, 32'd1234007, 1'b0, 1'b1, 1'b1);

      start = 1'b1; source1_data = 32'd9; source2_data = 32'd9; rd_addr = 5'd4;
      accumulate = 1'b1; destination_reg_data = 32'd1;
      cyc = 0;
      repeat (16) tick();
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("abort immediate", {busy, write, mac_control, done}, 4'b0);
      @(negedge clk) rst_n = 1'b1;
      nw = 0;
      repeat (40) begin
         tick();
         nw += int'(write);
      end
      chk("abort no write", nw, 0);
      run_op("after abort", 32'h0000_FFFF, 32'h0000_FFFF, 5'd9, 32'h0001_FFFF, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);

      start = 1'b1; source1_data = 32'd6; source2_data = 32'd7; rd_addr = 5'd12;
      accumulate = 1'b0; destination_reg_data = 32'd8;
      cyc = 0; nw = 0; nmc = 0; w1 = 0; w2 = 0; mc1 = 0; mc2 = 0;
      d1 = '0; d2 = '0; a1 = '0; a2 = '0;
      tick();
      source1_data = 32'd100; source2_data = 32'd3; rd_addr = 5'd13; accumulate = 1'b1;
      while (cyc < 72) begin
         if (write) begin
            nw++;
            if (nw == 1) begin w1 = cyc; d1 = wr_data; a1 = destination_register; end
            else begin w2 = cyc; d2 = wr_data; a2 = destination_register; end
         end
         if (mac_control) begin
            nmc++;
            if (nmc == 1) mc1 = cyc; else mc2 = cyc;
         end
         if (cyc == 35) start = 1'b0;
         tick();
      end
      chk("b2b write count", nw, 2);
      chk("b2b first write cycle", w1, 34);
      chk("b2b second write cycle", w2, 68);
      chk("b2b first data", {a1, d1}, {5'd12, 32'd42});
      chk("b2b second data", {a2, d2}, {5'd13, 32'd308});
      chk("b2b mac_control count", nmc, 2);
      chk("b2b mac_control cycles", {mc1[7:0], mc2[7:0]}, {8'd1, 8'd35});

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
